// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, sequencer FSM states, default word width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_NAND = 3'b001,
        OP_OR   = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_ADD  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } seq_state_t;

    // Opcodes that run the adder with an inverted B and a carry-in of one.
    function automatic logic op_is_sub(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic op_is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Classic combinational 1-bit MIPS ALU slice; set is the raw adder sum bit.
module alu
    import alu_pkg::*;
(
    input  logic       SrcA,
    input  logic       SrcB,
    input  logic       cin,
    input  logic       addSubSignal,
    input  logic       less,
    input  logic [2:0] ALUcontrol,
    output logic       ALUresult,
    output logic       cout,
    output logic       set
);

    logic b_s;
    logic sum_s;

    assign b_s   = SrcB ^ addSubSignal;
    assign sum_s = SrcA ^ b_s ^ cin;
    assign cout  = (SrcA & b_s) | (SrcA & cin) | (b_s & cin);
    assign set   = sum_s;

    // Per-opcode result select.
    always_comb begin
        ALUresult = 1'b0;
        case (alu_op_t'(ALUcontrol))
            OP_AND:  ALUresult = SrcA & SrcB;
            OP_NAND: ALUresult = ~(SrcA & SrcB);
            OP_OR:   ALUresult = SrcA | SrcB;
            OP_NOR:  ALUresult = ~(SrcA | SrcB);
            OP_XOR:  ALUresult = SrcA ^ SrcB;
            OP_ADD:  ALUresult = sum_s;
            OP_SUB:  ALUresult = sum_s;
            OP_SLT:  ALUresult = less;
            default: ALUresult = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial word ALU driving one 1-bit slice per cycle, LSB first.
// Optional ALU_SEQ_OVF_EN adds the overflow port and signed-correct SLT.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALUcontrol,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout_out
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    seq_state_t       state_r, state_nxt_s;
    alu_op_t          op_r, slice_op_s;
    logic [WIDTH-1:0] a_r, b_r, acc_r, acc_nxt_s;
    logic [IW-1:0]    idx_r, bit_s;
    logic             carry_r, set_r, less_s;
    logic             slice_res_s, slice_cout_s, slice_set_s;
    logic             busy_r, done_r, zero_r, cout_r;
    logic [WIDTH-1:0] result_r;
`ifdef ALU_SEQ_OVF_EN
    logic             ovf_r, overflow_r;
`endif

    alu u_slice (
        .SrcA        (a_r[bit_s]),
        .SrcB        (b_r[bit_s]),
        .cin         (carry_r),
        .addSubSignal(op_is_sub(op_r)),
        .less        (less_s),
        .ALUcontrol  (slice_op_s),
        .ALUresult   (slice_res_s),
        .cout        (slice_cout_s),
        .set         (slice_set_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) state_nxt_s = (op_r == OP_SLT) ? ST_FIX : ST_DONE;
                else                   state_nxt_s = ST_RUN;
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Slice drive: SLT runs as SUB first, then a one-bit fix-up pass on bit 0.
    always_comb begin
        slice_op_s = op_r;
        bit_s      = idx_r;
        less_s     = 1'b0;
        if (state_r == ST_FIX) begin
            slice_op_s = OP_SLT;
            bit_s      = '0;
`ifdef ALU_SEQ_OVF_EN
            less_s     = set_r ^ ovf_r;
`else
            less_s     = set_r;
`endif
        end else if (op_r == OP_SLT) begin
            slice_op_s = OP_SUB;
        end else begin
            slice_op_s = op_r;
        end
        acc_nxt_s        = acc_r;
        acc_nxt_s[idx_r] = slice_res_s;
    end

    // Datapath and registered outputs; visible outputs move only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r       <= OP_AND;
            a_r        <= '0;
            b_r        <= '0;
            acc_r      <= '0;
            idx_r      <= '0;
            carry_r    <= 1'b0;
            set_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            zero_r     <= 1'b0;
            cout_r     <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_r      <= 1'b0;
            overflow_r <= 1'b0;
`endif
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r    <= alu_op_t'(ALUcontrol);
                        a_r     <= srcA;
                        b_r     <= srcB;
                        acc_r   <= '0;
                        idx_r   <= '0;
                        carry_r <= op_is_sub(alu_op_t'(ALUcontrol));
                    end else begin
                        idx_r   <= '0;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_nxt_s;
                    carry_r <= slice_cout_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r <= '0;
                        set_r <= slice_set_s;
`ifdef ALU_SEQ_OVF_EN
                        ovf_r <= carry_r ^ slice_cout_s;
`endif
                        if (op_r != OP_SLT) begin
                            result_r   <= acc_nxt_s;
                            zero_r     <= (acc_nxt_s == '0);
                            cout_r     <= op_is_arith(op_r) & slice_cout_s;
`ifdef ALU_SEQ_OVF_EN
                            overflow_r <= op_is_arith(op_r) & (carry_r ^ slice_cout_s);
`endif
                        end else begin
                            cout_r <= 1'b0;
                        end
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                ST_FIX: begin
                    result_r   <= {{(WIDTH-1){1'b0}}, slice_res_s};
                    zero_r     <= ~slice_res_s;
                    cout_r     <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                    overflow_r <= ovf_r;
`endif
                end
                ST_DONE: begin
                    idx_r <= '0;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign zero     = zero_r;
    assign cout_out = cout_r;
`ifdef ALU_SEQ_OVF_EN
    assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=32).
module tb_alu_serial_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  ALUcontrol = 3'b000;
    logic [31:0] srcA = 32'h0, srcB = 32'h0;
    logic        busy, done, zero, cout_out;
    logic [31:0] result;
`ifdef ALU_SEQ_OVF_EN
    logic        overflow;
`endif

    int total = 0;
    int bad = 0;

    alu_serial_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUcontrol(ALUcontrol),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done),
        .result(result), .zero(zero), .cout_out(cout_out)
`ifdef ALU_SEQ_OVF_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    // Issue one op at a negedge; returns at the negedge where done is first seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        ALUcontrol = op; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy, done, zero, cout_out} !== 4'b0000) begin bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, zero, cout_out}); end
        total++; if (result !== 32'h0) begin bad++;
            $display("FAIL reset_result: got %h want 00000000", result); end
`ifdef ALU_SEQ_OVF_EN
        total++; if (overflow !== 1'b0) begin bad++;
            $display("FAIL reset_overflow: got %b want 0", overflow); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int cyc;
        logic [31:0] held;
        run_op(OP_ADD, 32'hFFFFFFFF, 32'h00000001, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL add_latency: got %0d want 33", cyc); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL add_result: got %h want 00000000", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL add_zero: got %b want 1", zero); end
        total++; if (cout_out !== 1'b1) begin bad++; $display("FAIL add_cout: got %b want 1", cout_out); end
`ifdef ALU_SEQ_OVF_EN
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL add_ovf: got %b want 0", overflow); end
`endif
        held = result;
        @(negedge clk);
        total++; if ({done, busy} !== 2'b00) begin bad++;
            $display("FAIL add_done_pulse: got done,busy=%b want 00", {done, busy}); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL add_held: got %h want %h", result, held); end
        run_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, cyc);
        total++; if (result !== 32'h80000000 || cout_out !== 1'b0) begin bad++;
            $display("FAIL add_signed_wrap: got %h/%b want 80000000/0", result, cout_out); end
`ifdef ALU_SEQ_OVF_EN
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL add_wrap_ovf: got %b want 1", overflow); end
`endif
        @(negedge clk);
    endtask

    task automatic test_sub();
        int cyc;
        run_op(OP_SUB, 32'h5, 32'h7, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL sub_latency: got %0d want 33", cyc); end
        total++; if (result !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_result: got %h want FFFFFFFE", result); end
        total++; if (zero !== 1'b0 || cout_out !== 1'b0) begin bad++;
            $display("FAIL sub_flags: got zero,cout=%b want 00", {zero, cout_out}); end
        @(negedge clk);
        run_op(OP_SUB, 32'h9, 32'h3, cyc);
        total++; if (result !== 32'h6 || cout_out !== 1'b1) begin bad++;
            $display("FAIL sub_pos: got %h/%b want 00000006/1", result, cout_out); end
        @(negedge clk);
    endtask

    task automatic test_slt();
        int cyc;
        run_op(OP_SLT, 32'h3, 32'h9, cyc);
        total++; if (cyc !== 34) begin bad++; $display("FAIL slt_latency: got %0d want 34", cyc); end
        total++; if (result !== 32'h1) begin bad++; $display("FAIL slt_3_9: got %h want 00000001", result); end
        total++; if (cout_out !== 1'b0 || zero !== 1'b0) begin bad++;
            $display("FAIL slt_flags: got cout,zero=%b want 00", {cout_out, zero}); end
        @(negedge clk);
        run_op(OP_SLT, 32'h9, 32'h3, cyc);
        total++; if (result !== 32'h0 || zero !== 1'b1) begin bad++;
            $display("FAIL slt_9_3: got %h/%b want 00000000/1", result, zero); end
        @(negedge clk);
        run_op(OP_SLT, 32'h80000000, 32'h00000001, cyc);
`ifdef ALU_SEQ_OVF_EN
        total++; if (result !== 32'h1) begin bad++; $display("FAIL slt_ovf_result: got %h want 00000001", result); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL slt_ovf_flag: got %b want 1", overflow); end
`else
        total++; if (result !== 32'h0) begin bad++; $display("FAIL slt_raw_result: got %h want 00000000", result); end
`endif
        @(negedge clk);
    endtask

    task automatic test_logic();
        int cyc;
        run_op(OP_NOR, 32'h0F0F0F0F, 32'h00FF00FF, cyc);
        total++; if (result !== 32'hF000F000) begin bad++; $display("FAIL nor: got %h want F000F000", result); end
        @(negedge clk);
        run_op(OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        total++; if (result !== 32'h0 || zero !== 1'b1 || cout_out !== 1'b0) begin bad++;
            $display("FAIL nand: got %h/%b/%b want 00000000/1/0", result, zero, cout_out); end
        @(negedge clk);
        run_op(OP_AND, 32'h0F0F0F0F, 32'h00FF00FF, cyc);
        total++; if (result !== 32'h000F000F) begin bad++; $display("FAIL and: got %h want 000F000F", result); end
        @(negedge clk);
        run_op(OP_OR, 32'h0F0F0F0F, 32'h00FF00FF, cyc);
        total++; if (result !== 32'h0FFF0FFF) begin bad++; $display("FAIL or: got %h want 0FFF0FFF", result); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int cyc;
        ALUcontrol = OP_ADD; srcA = 32'h1; srcB = 32'h2; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                start = 1'b1; ALUcontrol = OP_SUB; srcA = 32'h100; srcB = 32'h1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        total++; if (cyc !== 33) begin bad++; $display("FAIL ign_latency: got %0d want 33", cyc); end
        total++; if (result !== 32'h3) begin bad++; $display("FAIL ign_result: got %h want 00000003", result); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_queue: got busy=%b want 0", busy); end
    endtask

    task automatic test_rst_mid();
        int cyc;
        int seen;
        ALUcontrol = OP_ADD; srcA = 32'h12345678; srcB = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 11; i++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) begin bad++;
            $display("FAIL rst_mid_flags: got busy,done=%b want 00", {busy, done}); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_mid_result: got %h want 00000000", result); end
        rst = 1'b1;
        seen = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(OP_ADD, 32'd10, 32'd20, cyc);
        total++; if (result !== 32'd30) begin bad++; $display("FAIL b2b_first: got %h want 0000001E", result); end
        @(negedge clk);
        run_op(OP_XOR, 32'h0F0F0F0F, 32'hFF00FF00, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
        total++; if (result !== 32'hF00FF00F) begin bad++; $display("FAIL b2b_xor: got %h want F00FF00F", result); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
